rob_commit_unit: RTL and testbench

ROB_COMMIT_UNIT -- requirements
Module: rob_commit_unit

---
 rtl/rob_commit_if.sv | 48 ++++
 rtl/rob_commit_unit.sv | 95 +++++++++
 tb/tb_rob_commit_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// ROB commit bundle: head-entry status from the ROB towards the commit unit,
// and retirement, RAT, LSQ and flush controls coming back out of it.
interface rob_commit_if #(
   parameter int INDEX_WIDTH = 5,
   parameter int PREG_WIDTH  = 6,
   parameter int PC_WIDTH    = 32
);
   logic [INDEX_WIDTH-1:0] head_i;
   logic [INDEX_WIDTH:0]   occ_i;
   logic                   h0_done_i, h0_exc_i, h0_store_i, h0_wen_i;
   logic [4:0]             h0_areg_i;
   logic [PREG_WIDTH-1:0]  h0_preg_i;
   logic [PC_WIDTH-1:0]    h0_pc_i;
   logic                   h1_done_i, h1_exc_i, h1_store_i, h1_wen_i;
   logic [4:0]             h1_areg_i;
   logic [PREG_WIDTH-1:0]  h1_preg_i;
   logic                   st_ack_i;

   logic [1:0]             comcnt_o;
   logic                   rat_we0_o, rat_we1_o;
   logic [4:0]             rat_areg0_o, rat_areg1_o;
   logic [PREG_WIDTH-1:0]  rat_preg0_o, rat_preg1_o;
   logic                   st_commit_req_o;
   logic                   flush_o;
   logic [PC_WIDTH-1:0]    flush_pc_o;
   logic [INDEX_WIDTH-1:0] flush_index_o;
   logic [31:0]            retired_cnt_o;

   modport master (
      output head_i, occ_i,
             h0_done_i, h0_exc_i, h0_store_i, h0_wen_i, h0_areg_i, h0_preg_i, h0_pc_i,
             h1_done_i, h1_exc_i, h1_store_i, h1_wen_i, h1_areg_i, h1_preg_i,
             st_ack_i,
      input  comcnt_o, rat_we0_o, rat_areg0_o, rat_preg0_o,
             rat_we1_o, rat_areg1_o, rat_preg1_o,
             st_commit_req_o, flush_o, flush_pc_o, flush_index_o, retired_cnt_o
   );

   modport slave (
      input  head_i, occ_i,
             h0_done_i, h0_exc_i, h0_store_i, h0_wen_i, h0_areg_i, h0_preg_i, h0_pc_i,
             h1_done_i, h1_exc_i, h1_store_i, h1_wen_i, h1_areg_i, h1_preg_i,
             st_ack_i,
      output comcnt_o, rat_we0_o, rat_areg0_o, rat_preg0_o,
             rat_we1_o, rat_areg1_o, rat_preg1_o,
             st_commit_req_o, flush_o, flush_pc_o, flush_index_o, retired_cnt_o
   );
endinterface

// File: rtl/rob_commit_unit.sv
// Two-wide in-order ROB retirement: commits up to two head entries per cycle,
// serialises stores through the LSQ and raises a one-cycle flush on a faulting head.
module rob_commit_unit #(
   parameter int INDEX_WIDTH = 5,
   parameter int PREG_WIDTH  = 6,
   parameter int PC_WIDTH    = 32
) (
   input logic         clk,
   input logic         rst,
   rob_commit_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'd0, ST_WAIT = 2'd1, FLUSH = 2'd2} state_t;

   localparam logic [INDEX_WIDTH:0] OCC_ONE = (INDEX_WIDTH+1)'(1);
   localparam logic [INDEX_WIDTH:0] OCC_TWO = (INDEX_WIDTH+1)'(2);

   state_t                 r_state, w_next_state;
   logic                   r_st_req, r_flush;
   logic [PC_WIDTH-1:0]    r_flush_pc;
   logic [INDEX_WIDTH-1:0] r_flush_index;
   logic [31:0]            r_retired_cnt;

   logic                   w_slot0, w_slot1, w_flush_det;
   logic [1:0]             w_comcnt;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      w_next_state = r_state;
      w_slot0      = 1'b0;
      w_slot1      = 1'b0;
      w_flush_det  = 1'b0;
      if (!rst) begin
         unique case (r_state)
            RUN: begin
               if (bus.occ_i >= OCC_ONE && bus.h0_done_i) begin
                  if (bus.h0_exc_i) begin
                     w_flush_det  = 1'b1;
                     w_next_state = FLUSH;
                  end else if (bus.h0_store_i) begin
                     w_next_state = ST_WAIT;
                  end else begin
                     w_slot0 = 1'b1;
                     w_slot1 = bus.occ_i >= OCC_TWO && bus.h1_done_i &&
                               !bus.h1_exc_i && !bus.h1_store_i;
                  end
               end
            end
            ST_WAIT: begin
               if (bus.st_ack_i) begin
                  w_slot0      = 1'b1;
                  w_next_state = RUN;
               end
            end
            FLUSH:   w_next_state = RUN;
            default: w_next_state = RUN;
         endcase
      end
   end

   assign w_comcnt = {1'b0, w_slot0} + {1'b0, w_slot1};

   // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= RUN;
         r_st_req      <= 1'b0;
         r_flush       <= 1'b0;
         r_flush_pc    <= '0;
         r_flush_index <= '0;
         r_retired_cnt <= '0;
      end else begin
         r_state       <= w_next_state;
         r_st_req      <= (w_next_state == ST_WAIT);
         r_flush       <= w_flush_det;
         r_retired_cnt <= r_retired_cnt + 32'(w_comcnt);
         if (w_flush_det) begin
            r_flush_pc    <= bus.h0_pc_i;
            r_flush_index <= bus.head_i;
         end
      end
   end

   assign bus.comcnt_o        = w_comcnt;
   assign bus.rat_we0_o       = w_slot0 & bus.h0_wen_i;
   assign bus.rat_areg0_o     = bus.h0_areg_i;
   assign bus.rat_preg0_o     = bus.h0_preg_i;
   assign bus.rat_we1_o       = w_slot1 & bus.h1_wen_i;
   assign bus.rat_areg1_o     = bus.h1_areg_i;
   assign bus.rat_preg1_o     = bus.h1_preg_i;
   assign bus.st_commit_req_o = r_st_req;
   assign bus.flush_o         = r_flush;
   assign bus.flush_pc_o      = r_flush_pc;
   assign bus.flush_index_o   = r_flush_index;
   assign bus.retired_cnt_o   = r_retired_cnt;
endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: a vector table for single-cycle commit
// decisions plus hand-written store, flush and reset sequences.
module tb_rob_commit_unit;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] exp_ret = 0;

   always #5 clk = ~clk;

   rob_commit_if #(.INDEX_WIDTH(5), .PREG_WIDTH(6), .PC_WIDTH(32)) bus ();
   rob_commit_unit #(.INDEX_WIDTH(5), .PREG_WIDTH(6), .PC_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [5:0] occ;
      logic [4:0] head;
      logic       st_ack;
      logic       h0_done, h0_exc, h0_store, h0_wen;
      logic [4:0] h0_areg;
      logic [5:0] h0_preg;
      logic       h1_done, h1_exc, h1_store, h1_wen;
      logic [4:0] h1_areg;
      logic [5:0] h1_preg;
      logic [1:0] e_cnt;
      logic       e_we0, e_we1;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      bus.head_i = 5'd0;  bus.occ_i = 6'd0;  bus.st_ack_i = 1'b0;
      bus.h0_done_i = 1'b0; bus.h0_exc_i = 1'b0; bus.h0_store_i = 1'b0; bus.h0_wen_i = 1'b0;
      bus.h0_areg_i = 5'd0; bus.h0_preg_i = 6'd0; bus.h0_pc_i = 32'd0;
      bus.h1_done_i = 1'b0; bus.h1_exc_i = 1'b0; bus.h1_store_i = 1'b0; bus.h1_wen_i = 1'b0;
      bus.h1_areg_i = 5'd0; bus.h1_preg_i = 6'd0;
   endtask

   task automatic apply(input vec_t v);
      bus.occ_i = v.occ; bus.head_i = v.head; bus.st_ack_i = v.st_ack;
      bus.h0_done_i = v.h0_done; bus.h0_exc_i = v.h0_exc; bus.h0_store_i = v.h0_store;
      bus.h0_wen_i = v.h0_wen; bus.h0_areg_i = v.h0_areg; bus.h0_preg_i = v.h0_preg;
      bus.h1_done_i = v.h1_done; bus.h1_exc_i = v.h1_exc; bus.h1_store_i = v.h1_store;
      bus.h1_wen_i = v.h1_wen; bus.h1_areg_i = v.h1_areg; bus.h1_preg_i = v.h1_preg;
   endtask

   function automatic vec_t mk(input logic [5:0] occ, input logic [4:0] head, input logic ack,
                               input logic d0, input logic x0, input logic s0, input logic w0,
                               input logic [4:0] a0, input logic [5:0] p0,
                               input logic d1, input logic x1, input logic s1, input logic w1,
                               input logic [4:0] a1, input logic [5:0] p1,
                               input logic [1:0] cnt, input logic we0, input logic we1);
      vec_t v;
      v.occ = occ; v.head = head; v.st_ack = ack;
      v.h0_done = d0; v.h0_exc = x0; v.h0_store = s0; v.h0_wen = w0; v.h0_areg = a0; v.h0_preg = p0;
      v.h1_done = d1; v.h1_exc = x1; v.h1_store = s1; v.h1_wen = w1; v.h1_areg = a1; v.h1_preg = p1;
      v.e_cnt = cnt; v.e_we0 = we0; v.e_we1 = we1;
      return v;
   endfunction

   task automatic comb_chk(input string tag, input logic [1:0] cnt, input logic we0, input logic we1);
      check({tag, " comcnt"}, 32'(bus.comcnt_o), 32'(cnt));
      check({tag, " we0"}, 32'(bus.rat_we0_o), 32'(we0));
      check({tag, " we1"}, 32'(bus.rat_we1_o), 32'(we1));
   endtask

   initial begin
      //           occ head ack d0 x0 s0 w0 a0  p0  d1 x1 s1 w1 a1  p1  cnt we0 we1
      vecs[0] = mk(2,  0,  0,  1, 0, 0, 1, 3,  40, 1, 0, 0, 0, 5,  7,  2, 1, 0);
      vecs[1] = mk(3,  4,  0,  1, 0, 0, 1, 1,  2,  0, 0, 0, 1, 6,  8,  1, 1, 0);
      vecs[2] = mk(3,  4,  0,  0, 0, 0, 1, 1,  2,  1, 0, 0, 1, 6,  8,  0, 0, 0);
      vecs[3] = mk(0,  9,  0,  1, 0, 0, 1, 2,  9,  1, 0, 0, 1, 3,  10, 0, 0, 0);
      vecs[4] = mk(1,  9,  0,  1, 0, 0, 1, 2,  9,  1, 0, 0, 1, 3,  10, 1, 1, 0);
      vecs[5] = mk(2,  12, 0,  1, 0, 0, 1, 4,  11, 1, 1, 0, 1, 5,  12, 1, 1, 0);
      vecs[6] = mk(2,  12, 0,  1, 0, 0, 1, 4,  11, 1, 0, 1, 1, 5,  12, 1, 1, 0);
      vecs[7] = mk(2,  31, 1,  1, 0, 0, 1, 30, 63, 1, 0, 0, 1, 31, 33, 2, 1, 1);
      vecs[8] = mk(32, 20, 0,  1, 0, 0, 0, 7,  1,  1, 0, 0, 1, 8,  2,  2, 0, 1);
      vecs[9] = mk(1,  20, 1,  1, 0, 0, 0, 7,  1,  0, 0, 0, 0, 8,  2,  1, 0, 0);

      // Reset with a committable head present: nothing may retire while rst is high.
      rst = 1'b1;
      idle();
      bus.occ_i = 6'd2; bus.h0_done_i = 1'b1; bus.h0_wen_i = 1'b1;
      bus.h1_done_i = 1'b1; bus.h1_wen_i = 1'b1;
      #2;
      comb_chk("rst", 2'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0;
      idle();
      #2;
      check("rst req", 32'(bus.st_commit_req_o), 32'd0);
      check("rst flush", 32'(bus.flush_o), 32'd0);
      check("rst flush_pc", bus.flush_pc_o, 32'd0);
      check("rst flush_index", 32'(bus.flush_index_o), 32'd0);
      check("rst retired", bus.retired_cnt_o, 32'd0);

      // Table: single-cycle commit decisions in RUN (ack outside ST_WAIT is ignored).
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         apply(vecs[i]);
         #2;
         comb_chk($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_we0, vecs[i].e_we1);
         check($sformatf("vec%0d areg0", i), 32'(bus.rat_areg0_o), 32'(vecs[i].h0_areg));
         check($sformatf("vec%0d preg0", i), 32'(bus.rat_preg0_o), 32'(vecs[i].h0_preg));
         check($sformatf("vec%0d areg1", i), 32'(bus.rat_areg1_o), 32'(vecs[i].h1_areg));
         check($sformatf("vec%0d preg1", i), 32'(bus.rat_preg1_o), 32'(vecs[i].h1_preg));
         exp_ret += 32'(vecs[i].e_cnt);
         @(posedge clk); #1;
         check($sformatf("vec%0d retired", i), bus.retired_cnt_o, exp_ret);
         check($sformatf("vec%0d req", i), 32'(bus.st_commit_req_o), 32'd0);
         check($sformatf("vec%0d flush", i), 32'(bus.flush_o), 32'd0);
      end

      // Store at head=7, ack arrives after three waiting cycles.
      @(negedge clk);
      idle();
      bus.head_i = 5'd7; bus.occ_i = 6'd4;
      bus.h0_done_i = 1'b1; bus.h0_store_i = 1'b1; bus.h0_wen_i = 1'b1;
      bus.h0_areg_i = 5'd9; bus.h0_preg_i = 6'd17;
      bus.h1_done_i = 1'b1; bus.h1_wen_i = 1'b1; bus.h1_areg_i = 5'd2; bus.h1_preg_i = 6'd3;
      #2;
      comb_chk("st detect", 2'd0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check($sformatf("st wait%0d req", c), 32'(bus.st_commit_req_o), 32'd1);
         comb_chk($sformatf("st wait%0d", c), 2'd0, 1'b0, 1'b0);
      end
      @(negedge clk);
      bus.st_ack_i = 1'b1;
      #2;
      check("st ack req", 32'(bus.st_commit_req_o), 32'd1);
      comb_chk("st ack", 2'd1, 1'b1, 1'b0);
      check("st ack areg0", 32'(bus.rat_areg0_o), 32'd9);
      check("st ack preg0", 32'(bus.rat_preg0_o), 32'd17);
      exp_ret += 32'd1;
      @(posedge clk); #1;
      check("st after req", 32'(bus.st_commit_req_o), 32'd0);
      check("st after retired", bus.retired_cnt_o, exp_ret);
      @(negedge clk);
      idle();

      // Faulting head at index 31 that is also a store: exception wins.
      @(negedge clk);
      bus.head_i = 5'd31; bus.occ_i = 6'd3;
      bus.h0_done_i = 1'b1; bus.h0_exc_i = 1'b1; bus.h0_store_i = 1'b1; bus.h0_wen_i = 1'b1;
      bus.h0_pc_i = 32'h0000_1040;
      bus.h1_done_i = 1'b1; bus.h1_wen_i = 1'b1;
      #2;
      comb_chk("exc detect", 2'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("exc flush", 32'(bus.flush_o), 32'd1);
      check("exc flush_pc", bus.flush_pc_o, 32'h0000_1040);
      check("exc flush_index", 32'(bus.flush_index_o), 32'd31);
      check("exc req", 32'(bus.st_commit_req_o), 32'd0);
      check("exc retired", bus.retired_cnt_o, exp_ret);
      @(negedge clk);
      idle();
      bus.head_i = 5'd0; bus.occ_i = 6'd2; bus.h0_done_i = 1'b1; bus.h0_wen_i = 1'b1;
      bus.h0_pc_i = 32'h0000_2000;
      #2;
      comb_chk("flush state", 2'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("flush pulse end", 32'(bus.flush_o), 32'd0);
      check("flush_pc hold", bus.flush_pc_o, 32'h0000_1040);
      check("flush_index hold", 32'(bus.flush_index_o), 32'd31);
      check("flush retired", bus.retired_cnt_o, exp_ret);

      // Normal head with a store behind it: store waits to become the head.
      @(negedge clk);
      idle();
      bus.occ_i = 6'd2; bus.h0_done_i = 1'b1; bus.h0_wen_i = 1'b1;
      bus.h1_done_i = 1'b1; bus.h1_store_i = 1'b1;
      #2;
      comb_chk("st slot1", 2'd1, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("st slot1 req", 32'(bus.st_commit_req_o), 32'd0);
      @(negedge clk);
      idle();
      bus.occ_i = 6'd1; bus.h0_done_i = 1'b1; bus.h0_store_i = 1'b1;
      #2;
      comb_chk("st slot0", 2'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("st slot0 req", 32'(bus.st_commit_req_o), 32'd1);

      // Reset during ST_WAIT with a simultaneous ack: the ack is not consumed.
      @(negedge clk);
      rst = 1'b1;
      bus.st_ack_i = 1'b1;
      #2;
      comb_chk("rst ack", 2'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("rst ack req", 32'(bus.st_commit_req_o), 32'd0);
      check("rst ack retired", bus.retired_cnt_o, 32'd0);
      check("rst ack flush_pc", bus.flush_pc_o, 32'd0);

      // Exception presented while rst is high: no flush pulse follows.
      @(negedge clk);
      idle();
      bus.occ_i = 6'd1; bus.h0_done_i = 1'b1; bus.h0_exc_i = 1'b1; bus.h0_pc_i = 32'h0000_3000;
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0;
      idle();
      #2;
      check("rst exc flush", 32'(bus.flush_o), 32'd0);
      check("rst exc flush_pc", bus.flush_pc_o, 32'd0);
      @(posedge clk); #1;
      check("rst exc idle flush", 32'(bus.flush_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
